// File: rtl/key_bounce_gen_if.sv
// ---------------------------------------------------------------------------
// key_bounce_gen_if
//   Groups the control and status signals of the key bounce generator.
//
//   Signals
//     enable     1 = bounce emulation active, 0 = bypass (keyBounce follows keyClean)
//     keyClean   clean key level, synchronous to clk; 1 = released, 0 = pressed
//     keyBounce  emulated mechanical contact, registered
//     busy       high while a burst (chatter or settle hold) is in progress
//     done       one-cycle pulse when a burst finishes
//
//   Modports
//     master  drives enable/keyClean, observes the generator outputs
//     slave   the generator itself
// ---------------------------------------------------------------------------
interface key_bounce_gen_if;
  logic enable;
  logic keyClean;
  logic keyBounce;
  logic busy;
  logic done;

  modport master (
    output enable,
    output keyClean,
    input  keyBounce,
    input  busy,
    input  done
  );

  modport slave (
    input  enable,
    input  keyClean,
    output keyBounce,
    output busy,
    output done
  );
endinterface

// File: rtl/key_bounce_gen.sv
// ---------------------------------------------------------------------------
// key_bounce_gen
//   Emulates a chattering mechanical key contact for exercising debouncers.
//   On each clean-level change the output first jumps to the new level, then
//   toggles TOGGLES times with pseudo-random gaps of 1..2^GAP_BITS cycles,
//   is forced to the new level and held there for SETTLE cycles.
//
//   Parameters
//     TOGGLES   chatter toggles per edge (0..255)
//     GAP_BITS  LFSR bits used for the inter-toggle gap (1..8)
//     SETTLE    hold time after the chatter, in cycles (1..65535)
//
//   Ports
//     clk   single clock, rising edge
//     rst   synchronous, active-high reset
//     bus   key_bounce_gen_if.slave (enable, keyClean in; keyBounce, busy, done out)
// ---------------------------------------------------------------------------
module key_bounce_gen #(
  parameter int unsigned TOGGLES  = 8,
  parameter int unsigned GAP_BITS = 4,
  parameter logic [15:0] SETTLE   = 16'h0100
) (
  input logic             clk,
  input logic             rst,
  key_bounce_gen_if.slave bus
);

  // One extra bit so that the maximum gap 2^GAP_BITS is representable.
  localparam int GAP_W = GAP_BITS + 1;
  localparam int TOG_W = 8;
  localparam int SET_W = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic               kb_q,     kb_d;
  logic               target_q, target_d;
  logic [TOG_W-1:0]   tog_q,    tog_d;
  logic [GAP_W-1:0]   gap_q,    gap_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [15:0]        lfsr_q,   lfsr_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic               lfsr_fb;
  logic [GAP_W-1:0]   gap_load;

  // Fibonacci LFSR, taps 16,14,13,11. The seed is non-zero and the
  // polynomial is maximal-length, so the all-zero lock-up state is never hit.
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d   = {lfsr_q[14:0], lfsr_fb};

  // Zero-extended before the increment: an all-ones field gives 2^GAP_BITS,
  // never wraps to zero.
  assign gap_load = {1'b0, lfsr_q[GAP_BITS-1:0]} + GAP_W'(1);

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    kb_d     = kb_q;
    target_d = target_q;
    tog_d    = tog_q;
    gap_d    = gap_q;
    settle_d = settle_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          // A mismatch starts a burst; the first edge is a clean jump to the
          // new level. The done cycle is itself IDLE, so a pending mismatch
          // is picked up at the edge that ends it, never alongside it.
          if (bus.keyClean != kb_q) begin
            kb_d     = bus.keyClean;
            target_d = bus.keyClean;
            tog_d    = TOG_W'(TOGGLES);
            gap_d    = gap_load;
            state_d  = ST_BOUNCE;
          end
        end else begin
          // Bypass: plain one-register delay of the clean level.
          kb_d = bus.keyClean;
        end
      end

      ST_BOUNCE: begin
        // keyClean is deliberately ignored here: the burst always completes
        // toward the level latched at its start.
        if (gap_q <= GAP_W'(1)) begin
          if (tog_q != '0) begin
            kb_d  = ~kb_q;
            tog_d = tog_q - TOG_W'(1);
            gap_d = gap_load;
          end else begin
            // Final gap expired: land on the target regardless of the
            // toggle parity, then hold.
            kb_d     = target_q;
            settle_d = SETTLE;
            state_d  = ST_SETTLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      ST_SETTLE: begin
        kb_d = target_q;
        if (settle_q <= SET_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered alongside the state so busy is exactly "in BOUNCE or SETTLE".
    busy_d = (state_d != ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      kb_q     <= 1'b1;
      target_q <= 1'b1;
      tog_q    <= '0;
      gap_q    <= '0;
      settle_q <= '0;
      lfsr_q   <= LFSR_SEED;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kb_q     <= kb_d;
      target_q <= target_d;
      tog_q    <= tog_d;
      gap_q    <= gap_d;
      settle_q <= settle_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.keyBounce = kb_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/key_bounce_gen.md
KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

Interface
REQ-001 Parameter TOGGLES, default 8: number of chatter toggles per edge, range 0..255.
REQ-002 Parameter GAP_BITS, default 4: LFSR bits used for the inter-toggle gap, range 1..8.
REQ-003 Parameter SETTLE, default 16'h0100: hold time in cycles after chatter, range 1..65535.
REQ-004 clk  in  1  single clock, rising edge; all logic is synchronous to it.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  1 = bounce emulation; 0 = bypass.
REQ-007 keyClean  in  1  clean key level, synchronous to clk; 1 = released (idle), 0 = pressed.
REQ-008 keyBounce  out  1  emulated mechanical contact, registered; feeds a debouncer under test.
REQ-009 busy  out  1  high in BOUNCE or SETTLE.
REQ-010 done  out  1  one-cycle pulse on return to IDLE.

Function
REQ-011 FSM states SHALL be IDLE, BOUNCE and SETTLE, and the FSM SHALL be in IDLE after reset.
REQ-012 LFSR: 16-bit Fibonacci, taps 16,14,13,11; SHALL advance every cycle (not in reset); seed 16'hACE1; never zero.
REQ-013 gap load value SHALL be lfsr[GAP_BITS-1:0]+1, i.e. 1..2^GAP_BITS cycles, computed at the same width plus one bit with no wrap.
REQ-014 IDLE with enable=1 and keyClean != keyBounce: next edge SHALL set keyBounce<=keyClean, latch target<=keyClean, load toggle counter with TOGGLES, load gap, and enter BOUNCE.
REQ-015 BOUNCE: gap counter SHALL decrement each cycle; on expiry (gap==1) with toggles left >0, keyBounce SHALL invert, the toggle counter SHALL decrement, and gap SHALL reload.
REQ-016 BOUNCE: on gap expiry with toggles left ==0, keyBounce SHALL be forced to target, the settle counter SHALL load SETTLE, and the FSM SHALL enter SETTLE; TOGGLES=0 therefore yields a single clean edge plus one gap delay.
REQ-017 SETTLE: keyBounce SHALL hold target, and the settle counter SHALL decrement; when the counter reaches 1, the next edge SHALL enter IDLE and assert done for exactly that cycle.
REQ-018 keyClean changes while busy SHALL be ignored; after return to IDLE, any mismatch SHALL re-trigger per REQ-014 one cycle after done, never in the same cycle as done.
REQ-019 keyClean returning to the original level mid-burst SHALL NOT abort the burst; the burst SHALL complete to the latched target, then re-trigger toward the new level.
REQ-020 enable=0 in IDLE: keyBounce SHALL follow keyClean with 1-cycle register latency, busy=0, and done=0.
REQ-021 enable deasserted while busy: the burst SHALL complete normally, and bypass SHALL take effect in IDLE.
REQ-022 Maximum burst length SHALL be (TOGGLES+1)*2^GAP_BITS+SETTLE cycles; counters SHALL be sized to hold it with no wrap.

Reset
REQ-023 rst=1 at an edge SHALL give: state IDLE, keyBounce=1, busy=0, done=0, lfsr=16'hACE1, and all counters 0.
REQ-024 rst SHALL override every state, including mid-BOUNCE and mid-SETTLE; the first post-reset cycle SHALL re-evaluate per REQ-014 or REQ-020.
REQ-025 Output values SHALL be deterministic after reset: the same stimulus from reset SHALL produce an identical keyBounce waveform.

Verification
REQ-026 Reset then keyClean 1->0, enable=1, defaults -> keyBounce=0 one cycle later; exactly 8 further toggles, each 1..16 cycles apart; then 256 cycles stable at 0; one done pulse; busy high throughout.
REQ-027 TOGGLES=0, SETTLE=1 -> on a keyClean edge, keyBounce follows with no inversion, and done fires within 2+16 cycles.
REQ-028 keyClean 1->0 then back to 1 after 5 cycles -> burst ends at 0, done pulses, then a second burst toward 1 starts on the cycle after done; final keyBounce=1.
REQ-029 enable=0 with a random keyClean pattern -> keyBounce equals keyClean delayed by 1 cycle, and busy=done=0 always.
REQ-030 rst pulsed during BOUNCE (toggle 3 of 8) -> next cycle keyBounce=1, busy=0; a repeated stimulus reproduces the REQ-026 waveform exactly.
REQ-031 Loopback through a debouncer with a 255-cycle stable threshold -> a single clean output transition per keyClean edge, with no glitches.
